seq_serializer: RTL
===================

# seq_serializer

Upstream feeder for the sequence detector: accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a serial line that drives the detector's `seq_in`. A qualifier output marks which cycles carry payload bits. Back-to-back words stream with no idle gap. An optional per-word even-parity bit is appended after the data.

## Interface
- `WIDTH`, default 8: word width in bits; must be at least 2.
- `MSB_FIRST`, default 1: 1 shifts bit `WIDTH-1` first; 0 shifts bit 0 first.
- `IDLE_BIT`, default 0: level driven on `seq_out` when no bit is being sent.
- `clock`  input  1  sole clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_in`  input  WIDTH  parallel word; sampled only on handshake.
- `data_valid`  input  1  upstream has a word.
- `data_ready`  output  1  serializer can take a word this cycle.
- `seq_out`  output  1  serial bit stream (registered).
- `bit_valid`  output  1  `seq_out` carries a payload or parity bit this cycle (registered).
- `busy`  output  1  state is not IDLE.

## Operation
- **Reset.** While `reset` is high at a clock edge, the block goes to state IDLE with:
  - `seq_out=IDLE_BIT`, `bit_valid=0`, `busy=0`;
  - shift register and bit counter cleared.
- **data_ready.** `data_ready` is combinational and is forced to 0 while `reset` is high.
- **States:**
  - IDLE: `data_ready=1`.
    - Handshake → load the word into the shift register, clear the bit counter, go to SHIFT.
    - No handshake → stay in IDLE.
  - SHIFT: one bit per cycle, bit counter `0..WIDTH-1`.
    - Last bit, `SEQ_SER_PARITY_EN` undefined: `data_ready=1`. Handshake → reload and stay in SHIFT. No handshake → go to IDLE.
    - Last bit, `SEQ_SER_PARITY_EN` defined: `data_ready=0`, go to PARITY.
  - PARITY (macro only): the parity bit is on `seq_out`, `data_ready=1`. Handshake → reload and go to SHIFT. No handshake → go to IDLE.
- **Handshake.** A transfer occurs on an edge where `data_valid && data_ready`.
  - Upstream must hold `data_in` and `data_valid` stable until the transfer.
  - `data_valid` asserted while `data_ready=0` has no effect.
- **Data capture.** `data_in` is captured only at the transfer edge. Later changes do not affect the word being shifted.
- **Bit counter.** Width is `$clog2(WIDTH)`. It saturates at `WIDTH-1` and is reset on reload, so it never wraps inside a word.
- **IDLE output.** In IDLE, `seq_out` returns to `IDLE_BIT` and `bit_valid=0`.
- **Reset mid-word.** The partial word is discarded; no bit of it appears after reset is released.

## Timing
- **Latency.** A word accepted at edge N has its first bit on `seq_out` (with `bit_valid=1`) during cycle N+1. The last data bit appears in cycle N+WIDTH.
- **Back-to-back.** A handshake on the final-bit cycle gives gapless streaming:
  - `WIDTH` valid cycles per word without parity;
  - `WIDTH+1` valid cycles per word with parity.
- **Throughput.** One bit per clock. Peak word rate is one word per `WIDTH` (or `WIDTH+1`) cycles.
- **Reset release.** In the first cycle after `reset` deasserts, `data_ready=1`.

## Configuration
- **Macro:** `SEQ_SER_PARITY_EN`.
- **Defined:**
  - PARITY state exists.
  - One extra bit follows each word, equal to the XOR of all `WIDTH` data bits (even parity), with `bit_valid=1`.
  - `data_ready` moves from the last data bit to the parity cycle.
- **Undefined:**
  - No PARITY state and no extra bit.
  - The state encoding needs only IDLE and SHIFT.

## Structure
- **Shared package `seq_pkg`:**
  - state enum (IDLE, SHIFT, PARITY);
  - default `IDLE_BIT` constant;
  - the detector's state typedef.
- **Sub-modules:** none. The shift register, counter and FSM form one module of roughly 150–200 lines.

## Test plan
- **Single word.** `WIDTH=8`, `MSB_FIRST=1`, send `8'hB0` → `seq_out` = 1,0,1,1,0,0,0,0 over cycles N+1..N+8 with `bit_valid=1`. With the downstream detector attached, `det_o` pulses once, the cycle after the fourth bit.
- **Back-to-back.** `8'hA5` then `8'h3C`, `data_valid` held high → 16 consecutive `bit_valid` cycles reading 10100101 00111100, and `data_ready` high only in the last-bit cycles.
- **LSB first.** `MSB_FIRST=0`, send `8'h0D` → 1,0,1,1,0,0,0,0.
- **Reset mid-word.** Assert `reset` after 3 bits of `8'hFF` → next cycle `seq_out=IDLE_BIT`, `bit_valid=0`, `busy=0`. The next accepted word starts cleanly.
- **Parity.** With `SEQ_SER_PARITY_EN`, `8'hB0` → 8 data bits then parity bit 1. `8'h33` → parity bit 0. `bit_valid` runs for 9 cycles.
- **Stall.** `data_valid` high while busy → no capture. `data_in` changed mid-word → the shifted bits match the originally accepted word.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the serializer and the downstream sequence detector.
// The serializer state set grows a PARITY state when SEQ_SER_PARITY_EN is defined.
package seq_pkg;

`ifdef SEQ_SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;
`else
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;
`endif

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Detector states for the 1011 pattern fed by the serializer.
  typedef enum logic [2:0] {
    DET_IDLE  = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S101  = 3'd3,
    DET_S1011 = 3'd4
  } det_state_e;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder with valid/ready input and a registered bit stream.
// Define SEQ_SER_PARITY_EN to append an even-parity bit after every word.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             seq_out,
  output logic             bit_valid,
  output logic             busy
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seq_q, seq_d;
  logic             bv_q, bv_d;
`ifdef SEQ_SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             lastBit;
  logic             xfer;
  logic             loadBit;
  logic [WIDTH-1:0] loadShift;
  logic             nextBit;
  logic [WIDTH-1:0] nextShift;

  assign lastBit = (state_q == SHIFT) && (cnt_q == LAST_IDX);
  assign xfer    = data_valid && data_ready;
  assign busy    = (state_q != IDLE);
  assign seq_out   = seq_q;
  assign bit_valid = bv_q;

  // The first bit of a word goes straight to seq_out at the load edge, so the
  // shift register only holds the remaining bits, pre-shifted by one.
  assign loadBit   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign loadShift = MSB_FIRST ? {data_in[WIDTH-2:0], 1'b0} : {1'b0, data_in[WIDTH-1:1]};
  assign nextBit   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign nextShift = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};

  always_comb begin
    data_ready = 1'b0;
    if (!reset) begin
      if (state_q == IDLE) begin
        data_ready = 1'b1;
      end else if (state_q == SHIFT) begin
`ifdef SEQ_SER_PARITY_EN
        data_ready = 1'b0;
`else
        data_ready = lastBit;
`endif
      end else begin
        data_ready = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    bv_d     = bv_q;
`ifdef SEQ_SER_PARITY_EN
    parity_d = parity_q;
`endif

    if (xfer) begin
      state_d  = SHIFT;
      seq_d    = loadBit;
      shift_d  = loadShift;
      cnt_d    = '0;
      bv_d     = 1'b1;
`ifdef SEQ_SER_PARITY_EN
      parity_d = ^data_in;
`endif
    end else if (state_q == SHIFT && !lastBit) begin
      seq_d   = nextBit;
      shift_d = nextShift;
      cnt_d   = cnt_q + CW'(1);
      bv_d    = 1'b1;
    end else if (lastBit) begin
`ifdef SEQ_SER_PARITY_EN
      state_d = PARITY;
      seq_d   = parity_q;
      bv_d    = 1'b1;
`else
      state_d = IDLE;
      seq_d   = IDLE_BIT;
      bv_d    = 1'b0;
`endif
    end else begin
      // IDLE without a transfer, or PARITY without a follow-on word.
      state_d = IDLE;
      seq_d   = IDLE_BIT;
      bv_d    = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      seq_q    <= IDLE_BIT;
      bv_q     <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      seq_q    <= seq_d;
      bv_q     <= bv_d;
`ifdef SEQ_SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
